scr1_dmem_periph_router: RTL

SCR1_DMEM_PERIPH_ROUTER -- requirements
Module: scr1_dmem_periph_router

---
 rtl/scr1_dmem_periph_router_pkg.sv | 43 ++++
 rtl/scr1_dmem_periph_router_if.sv | 25 ++
 rtl/scr1_dmem_periph_router_addr_decode.sv | 25 ++
 rtl/scr1_dmem_periph_router.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/scr1_dmem_periph_router_pkg.sv
// Shared memory-interface definitions for the SCR1 data-memory router:
// bus widths, command/width/response encodings, port-select and FSM enums,
// and the default address map of the architecture.
package scr1_dmem_periph_router_pkg;

    localparam int unsigned SCR1_DMEM_AWIDTH = 32;
    localparam int unsigned SCR1_DMEM_DWIDTH = 32;

    // Architecture address map (scr1_arch_description constants)
    localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_TCM_ADDR_MASK    = 32'hFFFF_0000;
    localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_TCM_ADDR_PATTERN = 32'hF000_0000;
    localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_TMR_ADDR_MASK    = 32'hFFFF_FFE0;
    localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_TMR_ADDR_PATTERN = 32'hF004_0000;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        SCR1_DMEM_PORT_TCM = 2'b00,
        SCR1_DMEM_PORT_TMR = 2'b01,
        SCR1_DMEM_PORT_EXT = 2'b10
    } type_scr1_dmem_port_e;

    typedef enum logic {
        SCR1_FSM_ADDR = 1'b0,
        SCR1_FSM_DATA = 1'b1
    } type_scr1_dmem_fsm_e;

endpackage : scr1_dmem_periph_router_pkg

// File: rtl/scr1_dmem_periph_router_if.sv
// Data-memory request/response bus. The master drives the request,
// the slave answers with acknowledge, read data and response.
interface scr1_dmem_periph_router_if;
    import scr1_dmem_periph_router_pkg::*;

    logic                            req;
    type_scr1_mem_cmd_e              cmd;
    type_scr1_mem_width_e            width;
    logic [SCR1_DMEM_AWIDTH-1:0]     addr;
    logic [SCR1_DMEM_DWIDTH-1:0]     wdata;
    logic                            req_ack;
    logic [SCR1_DMEM_DWIDTH-1:0]     rdata;
    type_scr1_mem_resp_e             resp;

    modport master (
        output req, cmd, width, addr, wdata,
        input  req_ack, rdata, resp
    );

    modport slave (
        input  req, cmd, width, addr, wdata,
        output req_ack, rdata, resp
    );

endinterface : scr1_dmem_periph_router_if

// File: rtl/scr1_dmem_periph_router_addr_decode.sv
// Address decoder: maps an address onto TCM, timer or external port.
// The timer window is checked first so it wins wherever the regions overlap.
module scr1_dmem_addr_decode
    import scr1_dmem_periph_router_pkg::*;
#(
    parameter logic [SCR1_DMEM_AWIDTH-1:0] TCM_ADDR_MASK    = SCR1_TCM_ADDR_MASK,
    parameter logic [SCR1_DMEM_AWIDTH-1:0] TCM_ADDR_PATTERN = SCR1_TCM_ADDR_PATTERN,
    parameter logic [SCR1_DMEM_AWIDTH-1:0] TMR_ADDR_MASK    = SCR1_TMR_ADDR_MASK,
    parameter logic [SCR1_DMEM_AWIDTH-1:0] TMR_ADDR_PATTERN = SCR1_TMR_ADDR_PATTERN
)(
    input  logic [SCR1_DMEM_AWIDTH-1:0] addr_i,
    output type_scr1_dmem_port_e        sel_o
);

    // Priority region match: timer, then TCM, otherwise external
    always_comb begin
        sel_o = SCR1_DMEM_PORT_EXT;
        if ((addr_i & TMR_ADDR_MASK) == TMR_ADDR_PATTERN) begin
            sel_o = SCR1_DMEM_PORT_TMR;
        end else if ((addr_i & TCM_ADDR_MASK) == TCM_ADDR_PATTERN) begin
            sel_o = SCR1_DMEM_PORT_TCM;
        end
    end

endmodule : scr1_dmem_addr_decode

// File: rtl/scr1_dmem_periph_router.sv
// Data-memory router: forwards core requests to TCM, timer or external
// memory, keeps at most one transfer outstanding and steers the selected
// target's response back to the core with no added latency.
module scr1_dmem_periph_router
    import scr1_dmem_periph_router_pkg::*;
#(
    parameter logic [SCR1_DMEM_AWIDTH-1:0] TCM_ADDR_MASK    = SCR1_TCM_ADDR_MASK,
    parameter logic [SCR1_DMEM_AWIDTH-1:0] TCM_ADDR_PATTERN = SCR1_TCM_ADDR_PATTERN,
    parameter logic [SCR1_DMEM_AWIDTH-1:0] TMR_ADDR_MASK    = SCR1_TMR_ADDR_MASK,
    parameter logic [SCR1_DMEM_AWIDTH-1:0] TMR_ADDR_PATTERN = SCR1_TMR_ADDR_PATTERN
)(
    input  logic                       clk,
    input  logic                       rst,
    scr1_dmem_periph_router_if.slave   dmem,
    scr1_dmem_periph_router_if.master  tcm,
    scr1_dmem_periph_router_if.master  tmr,
    scr1_dmem_periph_router_if.master  ext
);

    type_scr1_dmem_fsm_e           state_q, state_d;
    type_scr1_dmem_port_e          port_sel_q, port_sel_d;
    type_scr1_dmem_port_e          sel;
    type_scr1_mem_resp_e           act_resp;
    logic [SCR1_DMEM_DWIDTH-1:0]   act_rdata;
    logic                          sel_ack;
    logic                          fwd;
    logic                          hs;

    scr1_dmem_addr_decode #(
        .TCM_ADDR_MASK    (TCM_ADDR_MASK),
        .TCM_ADDR_PATTERN (TCM_ADDR_PATTERN),
        .TMR_ADDR_MASK    (TMR_ADDR_MASK),
        .TMR_ADDR_PATTERN (TMR_ADDR_PATTERN)
    ) u_decode (
        .addr_i (dmem.addr),
        .sel_o  (sel)
    );

    // Request attributes go to every target unchanged
    assign tcm.cmd   = dmem.cmd;
    assign tcm.width = dmem.width;
    assign tcm.addr  = dmem.addr;
    assign tcm.wdata = dmem.wdata;
    assign tmr.cmd   = dmem.cmd;
    assign tmr.width = dmem.width;
    assign tmr.addr  = dmem.addr;
    assign tmr.wdata = dmem.wdata;
    assign ext.cmd   = dmem.cmd;
    assign ext.width = dmem.width;
    assign ext.addr  = dmem.addr;
    assign ext.wdata = dmem.wdata;

    // Response of the target owning the outstanding transfer
    always_comb begin
        act_resp  = tcm.resp;
        act_rdata = tcm.rdata;
        case (port_sel_q)
            SCR1_DMEM_PORT_TMR: begin
                act_resp  = tmr.resp;
                act_rdata = tmr.rdata;
            end
            SCR1_DMEM_PORT_EXT: begin
                act_resp  = ext.resp;
                act_rdata = ext.rdata;
            end
            default: begin
                act_resp  = tcm.resp;
                act_rdata = tcm.rdata;
            end
        endcase
    end

    // Acknowledge of the target addressed by the current request
    always_comb begin
        sel_ack = tcm.req_ack;
        case (sel)
            SCR1_DMEM_PORT_TMR: sel_ack = tmr.req_ack;
            SCR1_DMEM_PORT_EXT: sel_ack = ext.req_ack;
            default:            sel_ack = tcm.req_ack;
        endcase
    end

    // A new request may only go out when idle or when the previous one
    // completes successfully this very cycle; nothing escapes during reset.
    assign fwd = ~rst & dmem.req &
                 ((state_q == SCR1_FSM_ADDR) | (act_resp == SCR1_MEM_RESP_RDY_OK));
    assign hs  = fwd & sel_ack;

    assign tcm.req      = fwd & (sel == SCR1_DMEM_PORT_TCM);
    assign tmr.req      = fwd & (sel == SCR1_DMEM_PORT_TMR);
    assign ext.req      = fwd & (sel == SCR1_DMEM_PORT_EXT);
    assign dmem.req_ack = hs;

    // Core-side response: pass-through while a transfer is outstanding
    always_comb begin
        dmem.resp  = SCR1_MEM_RESP_NOTRDY;
        dmem.rdata = '0;
        if (state_q == SCR1_FSM_DATA) begin
            dmem.resp  = act_resp;
            dmem.rdata = act_rdata;
        end
    end

    // Next-state and port-select update
    always_comb begin
        state_d    = state_q;
        port_sel_d = port_sel_q;
        case (state_q)
            SCR1_FSM_ADDR: begin
                if (hs) begin
                    state_d    = SCR1_FSM_DATA;
                    port_sel_d = sel;
                end
            end
            SCR1_FSM_DATA: begin
                case (act_resp)
                    SCR1_MEM_RESP_RDY_OK: begin
                        if (hs) begin
                            port_sel_d = sel;
                        end else begin
                            state_d = SCR1_FSM_ADDR;
                        end
                    end
                    SCR1_MEM_RESP_RDY_ER: state_d = SCR1_FSM_ADDR;
                    default:              state_d = SCR1_FSM_DATA;
                endcase
            end
            default: state_d = SCR1_FSM_ADDR;
        endcase
    end

    // State and port-select registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SCR1_FSM_ADDR;
            port_sel_q <= SCR1_DMEM_PORT_EXT;
        end else begin
            state_q    <= state_d;
            port_sel_q <= port_sel_d;
        end
    end

endmodule : scr1_dmem_periph_router
